mon_product_radix: RTL and testbench

Parametrised Montgomery multiplier. It computes out_data = opA * opB * 2^-DATA_WIDTH mod opM.
- Consumes DIGIT_WIDTH bits of opB per cycle, using DIGIT_WIDTH unrolled radix-2 substeps.
- Valid/ready handshakes on both input and output.
- Final reduction is exact: result is always < opM.
- Sits in the modular arithmetic layer, under the point add/double controllers.

---
 rtl/mon_product_radix.sv | 165 ++++++++++++++++
 tb/tb_mon_product_radix.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mon_product_radix.sv
// ============================================================================
// Module   : mon_product_radix
// Function : radix-2^DIGIT_WIDTH Montgomery product, out = A*B*2^-DATA_WIDTH mod M.
//            Optional operand check enabled by macro MONPRO_CHK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mon_product_radix #(
    parameter int DATA_WIDTH  = 256,
    parameter int DIGIT_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] opA,
    input  logic [DATA_WIDTH-1:0] opB,
    input  logic [DATA_WIDTH-1:0] opM,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  err
);

    localparam int ITER  = DATA_WIDTH / DIGIT_WIDTH;
    localparam int CNT_W = $clog2(ITER) + 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_RED  = 2'd2;
    localparam logic [1:0] c_OUT  = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_m;
    logic [DATA_WIDTH+1:0] r_s;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;

    logic                  w_accept;
    logic                  w_calc;
    logic                  w_load_out;
    logic                  w_release;
    logic [DATA_WIDTH+1:0] w_s_next;
    logic [DATA_WIDTH+1:0] w_red_full;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: if (in_valid) w_next_state = c_CALC;
            c_CALC: if (r_cnt == CNT_W'(ITER - 1)) w_next_state = c_RED;
            c_RED:  w_next_state = c_OUT;
            c_OUT:  if (out_ready) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        in_ready   = (r_state == c_IDLE);
        w_accept   = (r_state == c_IDLE) && in_valid;
        w_calc     = (r_state == c_CALC);
        w_load_out = (r_state == c_RED);
        w_release  = (r_state == c_OUT) && out_ready;
    end

    // Unrolled radix-2 steps; s stays below 2*M so DATA_WIDTH+2 bits suffice.
    always_comb begin
        logic [DATA_WIDTH+1:0] s_t;
        logic [DATA_WIDTH+2:0] sum_t;
        logic                  b_t;
        logic                  q_t;
        s_t   = r_s;
        sum_t = '0;
        b_t   = 1'b0;
        q_t   = 1'b0;
        for (int j = 0; j < DIGIT_WIDTH; j++) begin
            b_t   = r_b[j];
            q_t   = s_t[0] ^ (b_t & r_a[0]);
            sum_t = {1'b0, s_t}
                  + (b_t ? {3'b000, r_a} : {(DATA_WIDTH+3){1'b0}})
                  + (q_t ? {3'b000, r_m} : {(DATA_WIDTH+3){1'b0}});
            s_t   = sum_t[DATA_WIDTH+2:1];
        end
        w_s_next = s_t;
    end

    assign w_red_full = (r_s >= {2'b00, r_m}) ? (r_s - {2'b00, r_m}) : r_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_m         <= '0;
            r_s         <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= opA;
                r_b   <= opB;
                r_m   <= opM;
                r_s   <= '0;
                r_cnt <= '0;
            end
            if (w_calc) begin
                r_s   <= w_s_next;
                r_b   <= r_b >> DIGIT_WIDTH;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_load_out) begin
                r_out_data  <= w_red_full[DATA_WIDTH-1:0];
                r_out_valid <= 1'b1;
            end
            if (w_release) begin
                r_out_data  <= '0;
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

`ifdef MONPRO_CHK_EN
    logic w_chk;
    logic r_chk;
    logic r_err;

    assign w_chk = ~opM[0] | (opA >= opM) | (opB >= opM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_chk <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (w_accept)   r_chk <= w_chk;
            if (w_load_out) r_err <= r_chk;
            if (w_release)  r_err <= 1'b0;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mon_product_radix.sv
// ============================================================================
// Module   : tb_mon_product_radix
// Function : self-checking bench for mon_product_radix (8/2 and 256/4 instances)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mon_product_radix;

    localparam int SW = 8;
    localparam int SD = 2;
    localparam int BW = 256;
    localparam int BD = 4;
    localparam int B_ITER = BW / BD;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_err;
    logic [SW-1:0] s_opA, s_opB, s_opM, s_out_data;
    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err;
    logic [BW-1:0] b_opA, b_opB, b_opM, b_out_data;

    mon_product_radix #(.DATA_WIDTH(SW), .DIGIT_WIDTH(SD)) u_small (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .opA(s_opA), .opB(s_opB), .opM(s_opM),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .err(s_err)
    );

    mon_product_radix #(.DATA_WIDTH(BW), .DIGIT_WIDTH(BD)) u_big (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .opA(b_opA), .opB(b_opB), .opM(b_opM),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .err(b_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [255:0] sq[$];
    logic [255:0] bq[$];

    // Reference: modular product by shift-and-add, then n modular halvings.
    function automatic logic [255:0] mont_ref(input logic [255:0] a, input logic [255:0] b,
                                              input logic [255:0] m, input int n);
        logic [257:0] r;
        logic [257:0] mm;
        mm = {2'b00, m};
        r  = '0;
        for (int i = n - 1; i >= 0; i--) begin
            r = r << 1;
            if (r >= mm) r = r - mm;
            if (b[i]) begin
                r = r + {2'b00, a};
                if (r >= mm) r = r - mm;
            end
        end
        for (int i = 0; i < n; i++) r = r[0] ? ((r + mm) >> 1) : (r >> 1);
        return r[255:0];
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic s_issue(input logic [SW-1:0] a, input logic [SW-1:0] b, input logic [SW-1:0] m);
        s_opA = a; s_opB = b; s_opM = m;
        s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
    endtask

    task automatic s_wait(output int lat);
        lat = 0;
        while (!s_out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic s_result(input string tag);
        int lat;
        logic [255:0] e;
        s_wait(lat);
        check({tag, "_latency"}, 256'(lat), 256'd5);
        e = sq.pop_front();
        check({tag, "_data"}, {248'b0, s_out_data}, e);
    endtask

    task automatic rand256(output logic [255:0] r);
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [255:0] m, a, b, e;
        logic seen;

        rst_n = 1'b0;
        s_in_valid = 1'b0; s_opA = '0; s_opB = '0; s_opM = '0; s_out_ready = 1'b1;
        b_in_valid = 1'b0; b_opA = '0; b_opB = '0; b_opM = '0; b_out_ready = 1'b1;
        tick(); tick();
        check("reset_in_ready",  256'(s_in_ready), 256'd1);
        check("reset_out_valid", 256'(s_out_valid), 256'd0);
        check("reset_out_data",  {248'b0, s_out_data}, 256'd0);
        check("reset_err",       256'(s_err), 256'd0);
        rst_n = 1'b1;
        tick();

        // Basic
        sq.push_back(256'd1);
        s_issue(8'd5, 8'd7, 8'd13);
        check("basic_in_ready_drop", 256'(s_in_ready), 256'd0);
        s_result("basic");
        check("basic_err", 256'(s_err), 256'd0);
        tick();
        check("basic_idle_in_ready",  256'(s_in_ready), 256'd1);
        check("basic_idle_out_valid", 256'(s_out_valid), 256'd0);
        check("basic_idle_out_data",  {248'b0, s_out_data}, 256'd0);

        // Wrap-high and zero operand
        sq.push_back(256'd3);
        s_issue(8'd12, 8'd12, 8'd13);
        s_result("wrap_high");
        tick();
        sq.push_back(256'd0);
        s_issue(8'd0, 8'd9, 8'd13);
        s_result("zero");
        tick();

        // Backpressure with an ignored request while holding
        s_out_ready = 1'b0;
        sq.push_back(mont_ref(256'd3, 256'd4, 256'd13, SW));
        s_issue(8'd3, 8'd4, 8'd13);
        s_result("bp");
        e = {248'b0, s_out_data};
        s_opA = 8'd1; s_opB = 8'd1; s_opM = 8'd11;
        s_in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_hold_valid",    256'(s_out_valid), 256'd1);
            check("bp_hold_data",     {248'b0, s_out_data}, e);
            check("bp_hold_in_ready", 256'(s_in_ready), 256'd0);
        end
        s_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        tick();
        check("bp_release_in_ready",  256'(s_in_ready), 256'd1);
        check("bp_release_out_valid", 256'(s_out_valid), 256'd0);
        sq.push_back(mont_ref(256'd9, 256'd11, 256'd13, SW));
        s_issue(8'd9, 8'd11, 8'd13);
        s_result("bp_second");
        tick();

        // Reset during CALC at cnt == 2
        s_issue(8'd7, 8'd8, 8'd13);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_in_ready",  256'(s_in_ready), 256'd1);
        check("midrst_out_valid", 256'(s_out_valid), 256'd0);
        check("midrst_out_data",  {248'b0, s_out_data}, 256'd0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (s_out_valid) seen = 1'b1;
        end
        check("midrst_no_stale_result", 256'(seen), 256'd0);
        sq.push_back(mont_ref(256'd6, 256'd10, 256'd13, SW));
        s_issue(8'd6, 8'd10, 8'd13);
        s_result("midrst_after");
        tick();

        // Even modulus raises err only when the check is built
        s_issue(8'd3, 8'd4, 8'd12);
        s_wait(lat);
        check("err_latency", 256'(lat), 256'd5);
`ifdef MONPRO_CHK_EN
        check("err_even_mod", 256'(s_err), 256'd1);
`else
        check("err_even_mod", 256'(s_err), 256'd0);
`endif
        tick();
        check("err_cleared", 256'(s_err), 256'd0);

        // 256-bit random sweep
        for (int t = 0; t < 200; t++) begin
            rand256(m);
            m[255] = 1'b1;
            m[0]   = 1'b1;
            rand256(a);
            rand256(b);
            if (t == 0) begin
                a = m - 256'd1; b = m - 256'd1;
            end else if (t == 1) begin
                a = '0;
            end else begin
                a = a % m; b = b % m;
            end
            bq.push_back(mont_ref(a, b, m, BW));
            b_opA = a; b_opB = b; b_opM = m;
            b_in_valid = 1'b1;
            tick();
            b_in_valid = 1'b0;
            lat = 0;
            while (!b_out_valid && lat < B_ITER + 10) begin
                tick();
                lat++;
            end
            if (t == 0) check("sweep_latency", 256'(lat), 256'(B_ITER + 1));
            e = bq.pop_front();
            check("sweep_data", b_out_data, e);
            check("sweep_lt_mod", 256'(b_out_data < m), 256'd1);
            if (t == 2) check("sweep_err", 256'(b_err), 256'd0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
